// File: rtl/hist_pkg.sv
// hist_pkg: shared types and helpers for the multi-channel histogram block.
// Holds the control state enum, default width constants and the bin-field
// extraction function used by the top level.
// Optional feature macro used elsewhere in this slice: HIST_DROP_CNT_EN.
package hist_pkg;

    // Control states of the window/readout sequencer
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_DUMP  = 3'd2,
        ST_MODE  = 3'd3,
        ST_DONE  = 3'd4
    } hist_state_e;

    // Default geometry
    localparam int DEF_NUM_CH   = 4;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_BIN_BITS = 6;
    localparam int DEF_BIN_LSB  = 0;
    localparam int DEF_CNT_W    = 16;

    // Widest bin field the extraction helper returns
    localparam int BIN_FN_W = 16;

    // Extracts sample[lsb +: bits]; callers cast the result to their bin width.
    function automatic logic [BIN_FN_W-1:0] extract_bin(
        input logic [63:0] sample,
        input int          lsb,
        input int          bits
    );
        logic [63:0] w_shifted;
        logic [63:0] w_mask;
        w_shifted = sample >> lsb;
        w_mask    = (64'd1 << bits) - 64'd1;
        return BIN_FN_W'(w_shifted & w_mask);
    endfunction

endpackage

// File: rtl/hist_ch_bank.sv
// hist_ch_bank: one channel's histogram storage.
// 2^BIN_BITS saturating counters with an increment port (accumulation) and a
// read/clear port (readout), plus the running max / arg-max tracker that is
// fed by the read port while bins are streamed out.
module hist_ch_bank
    import hist_pkg::*;
#(
    parameter int BIN_BITS = DEF_BIN_BITS,
    parameter int CNT_W    = DEF_CNT_W
)(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_inc,
    input  logic [BIN_BITS-1:0] i_inc_bin,
    input  logic [BIN_BITS-1:0] i_rd_bin,
    input  logic                i_rd_clr,
    output logic [CNT_W-1:0]    o_rd_data,
    input  logic                i_max_upd,
    input  logic                i_max_clr,
    output logic [BIN_BITS-1:0] o_max_idx
);

    localparam int              NUM_BINS = 1 << BIN_BITS;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    r_bins [NUM_BINS];
    logic [CNT_W-1:0]    r_max_cnt;
    logic [BIN_BITS-1:0] r_max_idx;

    assign o_rd_data = r_bins[i_rd_bin];
    assign o_max_idx = r_max_idx;

    // Counter array: saturating increment, clear-on-read wins if both hit one bin
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NUM_BINS; i++) begin
                r_bins[i] <= '0;
            end
        end else begin
            if (i_inc && (r_bins[i_inc_bin] != CNT_MAX)) begin
                r_bins[i_inc_bin] <= r_bins[i_inc_bin] + CNT_W'(1);
            end
            if (i_rd_clr) begin
                r_bins[i_rd_bin] <= '0;
            end
        end
    end

    // Running max: strictly-greater update keeps the lowest bin on ties,
    // and an all-zero channel never updates so it reports bin 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_max_cnt <= '0;
            r_max_idx <= '0;
        end else if (i_max_clr) begin
            r_max_cnt <= '0;
            r_max_idx <= '0;
        end else if (i_max_upd && (o_rd_data > r_max_cnt)) begin
            r_max_cnt <= o_rd_data;
            r_max_idx <= i_rd_bin;
        end
    end

endmodule

// File: rtl/multi_ch_hist.sv
// multi_ch_hist: NUM_CH-lane histogram with windowed accumulation and
// streamed readout of every bin followed by each channel's mode.
// Optional: define HIST_DROP_CNT_EN to add the drop_count output, a saturating
// count of valid cycles that arrive outside the accumulation window.
//
// Output handshake (freq_* and mode_*): FIFO-write style. A word transfers in
// exactly the cycle its write strobe is 1. The strobe is only raised in a
// cycle where the matching full_n is 1, so full_n acts as ready and the word
// is held (position not advanced) in any cycle where full_n is 0.
module multi_ch_hist
    import hist_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int BIN_BITS = DEF_BIN_BITS,
    parameter int BIN_LSB  = DEF_BIN_LSB,
    parameter int CNT_W    = DEF_CNT_W
)(
    input  logic                     ap_clk,
    input  logic                     aresetn,
    input  logic                     ap_start,
    output logic                     ap_idle,
    output logic                     ap_done,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic                     input_valid,
    input  logic [31:0]              accumulation,
    output logic [CNT_W-1:0]         freq_din,
    output logic                     freq_write,
    input  logic                     freq_full_n,
    output logic [CNT_W-1:0]         mode_din,
    output logic                     mode_write,
    input  logic                     mode_full_n,
    output logic [2:0]               o_dbg_state
`ifdef HIST_DROP_CNT_EN
    ,
    output logic [31:0]              drop_count
`endif
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    hist_state_e         r_state;
    hist_state_e         w_state_nxt;

    logic [31:0]         r_win_len;
    logic [31:0]         r_smp_cnt;
    logic [CH_W-1:0]     r_ch;
    logic [BIN_BITS-1:0] r_bin;

    logic                w_go;
    logic                w_acc_inc;
    logic                w_emit;
    logic                w_mode_emit;
    logic                w_last_smp;
    logic                w_last_bin;
    logic                w_last_ch;

    logic [BIN_BITS-1:0] w_lane_bin [NUM_CH];
    logic [CNT_W-1:0]    w_rd_data  [NUM_CH];
    logic [BIN_BITS-1:0] w_max_idx  [NUM_CH];
    logic [CNT_W-1:0]    w_rd_sel;
    logic [BIN_BITS-1:0] w_max_sel;

    assign w_last_smp  = (r_smp_cnt == (r_win_len - 32'd1));
    assign w_last_bin  = (r_bin == {BIN_BITS{1'b1}});
    assign w_last_ch   = (r_ch == CH_W'(NUM_CH - 1));
    assign w_rd_sel    = w_rd_data[r_ch];
    assign w_max_sel   = w_max_idx[r_ch];
    assign o_dbg_state = r_state;

    // One bank per lane; all lanes count together, readout addresses one bank
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic w_sel;
        assign w_sel = (r_ch == CH_W'(c));
        assign w_lane_bin[c] = BIN_BITS'(extract_bin(64'(data_in[c*DATA_W +: DATA_W]),
                                                     BIN_LSB, BIN_BITS));

        hist_ch_bank #(
            .BIN_BITS (BIN_BITS),
            .CNT_W    (CNT_W)
        ) u_bank (
            .i_clk     (ap_clk),
            .i_rst_n   (aresetn),
            .i_inc     (w_acc_inc),
            .i_inc_bin (w_lane_bin[c]),
            .i_rd_bin  (r_bin),
            .i_rd_clr  (w_emit && w_sel),
            .o_rd_data (w_rd_data[c]),
            .i_max_upd (w_emit && w_sel),
            .i_max_clr (w_mode_emit && w_sel),
            .o_max_idx (w_max_idx[c])
        );
    end

    // State register
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath strobes and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_go        = 1'b0;
        w_acc_inc   = 1'b0;
        w_emit      = 1'b0;
        w_mode_emit = 1'b0;
        ap_idle     = 1'b0;
        ap_done     = 1'b0;
        freq_write  = 1'b0;
        freq_din    = '0;
        mode_write  = 1'b0;
        mode_din    = '0;
        case (r_state)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start && (accumulation != 32'd0)) begin
                    w_go        = 1'b1;
                    w_state_nxt = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (input_valid) begin
                    w_acc_inc = 1'b1;
                    if (w_last_smp) begin
                        w_state_nxt = ST_DUMP;
                    end
                end
            end
            ST_DUMP: begin
                if (freq_full_n) begin
                    w_emit     = 1'b1;
                    freq_write = 1'b1;
                    freq_din   = w_rd_sel;
                    if (w_last_bin) begin
                        w_state_nxt = ST_MODE;
                    end
                end
            end
            ST_MODE: begin
                if (mode_full_n) begin
                    w_mode_emit = 1'b1;
                    mode_write  = 1'b1;
                    mode_din    = CNT_W'(w_max_sel);
                    w_state_nxt = w_last_ch ? ST_DONE : ST_DUMP;
                end
            end
            ST_DONE: begin
                ap_done     = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Window length, sample counter and readout position
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_win_len <= '0;
            r_smp_cnt <= '0;
            r_ch      <= '0;
            r_bin     <= '0;
        end else begin
            if (w_go) begin
                r_win_len <= accumulation;
                r_smp_cnt <= '0;
                r_ch      <= '0;
                r_bin     <= '0;
            end
            if (w_acc_inc) begin
                r_smp_cnt <= r_smp_cnt + 32'd1;
            end
            // r_bin wraps to 0 after the last bin, ready for the next channel
            if (w_emit) begin
                r_bin <= r_bin + BIN_BITS'(1);
            end
            if (w_mode_emit) begin
                r_ch <= w_last_ch ? '0 : (r_ch + CH_W'(1));
            end
        end
    end

`ifdef HIST_DROP_CNT_EN
    logic [31:0] r_drop_cnt;

    // Saturating count of valid samples presented outside the window
    always_ff @(posedge ap_clk or negedge aresetn) begin
        if (!aresetn) begin
            r_drop_cnt <= '0;
        end else if (w_go) begin
            r_drop_cnt <= '0;
        end else if (input_valid && (r_state != ST_ACCUM) && (r_drop_cnt != 32'hFFFF_FFFF)) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
        end
    end

    assign drop_count = r_drop_cnt;
`endif

endmodule

// File: tb/tb_multi_ch_hist.sv
// tb_multi_ch_hist: randomized windows checked against a behavioural
// histogram model (per-window count arrays, saturation and arg-max computed
// directly from the sample list), plus literal expectations per scenario.
module tb_multi_ch_hist;

  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 16;
  localparam int BIN_BITS = 6;
  localparam int CNT_W    = 16;
  localparam int NB       = 1 << BIN_BITS;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic                     ap_clk;
  logic                     aresetn;
  logic                     ap_start;
  logic                     ap_idle;
  logic                     ap_done;
  logic [NUM_CH*DATA_W-1:0] data_in;
  logic                     input_valid;
  logic [31:0]              accumulation;
  logic [CNT_W-1:0]         freq_din;
  logic                     freq_write;
  logic                     freq_full_n = 1'b1;
  logic [CNT_W-1:0]         mode_din;
  logic                     mode_write;
  logic                     mode_full_n = 1'b1;
  logic [2:0]               o_dbg_state;
`ifdef HIST_DROP_CNT_EN
  logic [31:0]              drop_count;
`endif

  multi_ch_hist dut (
    .ap_clk       (ap_clk),
    .aresetn      (aresetn),
    .ap_start     (ap_start),
    .ap_idle      (ap_idle),
    .ap_done      (ap_done),
    .data_in      (data_in),
    .input_valid  (input_valid),
    .accumulation (accumulation),
    .freq_din     (freq_din),
    .freq_write   (freq_write),
    .freq_full_n  (freq_full_n),
    .mode_din     (mode_din),
    .mode_write   (mode_write),
    .mode_full_n  (mode_full_n),
    .o_dbg_state  (o_dbg_state)
`ifdef HIST_DROP_CNT_EN
    ,
    .drop_count   (drop_count)
`endif
  );

  // ---------------- clock ----------------
  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [CNT_W:0] exp_q[$];          // {is_mode, value} in required output order
  int freq_total = 0;
  int mode_total = 0;
  int done_total = 0;
  int win_freq   = 0;
  int win_mode   = 0;
  logic [CNT_W-1:0] cap_freq [NUM_CH*NB];
  logic [CNT_W-1:0] cap_mode [NUM_CH];
  int mcnt [NUM_CH][NB];
  bit bp_en       = 1'b0;
  int stall_left  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge ap_clk) begin
    logic [CNT_W:0] e;
    if (!aresetn) begin
      win_freq = 0;
      win_mode = 0;
    end else begin
      chk("freq_write_while_full", 64'(freq_write & ~freq_full_n), 0);
      chk("mode_write_while_full", 64'(mode_write & ~mode_full_n), 0);
      if (freq_write) begin
        if (exp_q.size() == 0) begin
          chk("freq_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("freq_word", {1'b0, freq_din}, e);
        end
        if (win_freq < NUM_CH*NB) cap_freq[win_freq] = freq_din;
        win_freq++;
        freq_total++;
      end
      if (mode_write) begin
        if (exp_q.size() == 0) begin
          chk("mode_unexpected_word", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("mode_word", {1'b1, mode_din}, e);
        end
        if (win_mode < NUM_CH) cap_mode[win_mode] = mode_din;
        win_mode++;
        mode_total++;
      end
      if (ap_done) begin
        chk("done_freq_count", win_freq, NUM_CH*NB);
        chk("done_mode_count", win_mode, NUM_CH);
        chk("done_queue_empty", exp_q.size(), 0);
        done_total++;
        win_freq = 0;
        win_mode = 0;
      end
    end
  end

  // ---------------- downstream full_n driver ----------------
  always @(posedge ap_clk) begin
    #1;
    if (bp_en) begin
      freq_full_n = ~freq_full_n;
      if (win_freq == 3*NB && win_mode == 2 && stall_left > 0) begin
        mode_full_n = 1'b0;
        stall_left--;
      end else begin
        mode_full_n = 1'b1;
      end
    end else begin
      freq_full_n = 1'b1;
      mode_full_n = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DATA_W-1:0] gen(input int pat, input int c, input int k);
    int b;
    case (pat)
      0:       b = (c == 0) ? 3 : (c == 1) ? (((k % 3) == 2) ? 7 : 5) : 0;
      1:       b = 1;
      3:       b = (c == 0) ? ((k < 5) ? 4 : 9) : (c == 3) ? 0 : int'($urandom_range(0, NB-1));
      4:       b = 2;
      default: b = int'($urandom_range(0, NB-1));
    endcase
    return {10'($urandom_range(0, 1023)), 6'(b)};
  endfunction

  task automatic junk();
    input_valid = 1'($urandom_range(0, 1));
    data_in     = {$urandom, $urandom};
  endtask

  task automatic start_window(input int n, input bit hold);
    int cyc = 0;
    while (!ap_idle && cyc < 2000) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    chk("idle_before_start", ap_idle, 1);
    ap_start     = 1'b1;
    accumulation = 32'(n);
    junk();
    @(posedge ap_clk); #1;
    ap_start = hold;
    chk("left_idle_on_start", ap_idle, 0);
  endtask

  // Drives n counted samples, then queues the window's expected output
  task automatic send_samples(input int n, input int pat, input bit dense);
    int k = 0;
    logic [DATA_W-1:0] d;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < NB; b++) mcnt[c][b] = 0;
    while (k < n) begin
      if (dense || $urandom_range(0, 3) != 0) begin
        input_valid = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
          d = gen(pat, c, k);
          data_in[c*DATA_W +: DATA_W] = d;
          mcnt[c][d[BIN_BITS-1:0]]++;
        end
        k++;
      end else begin
        input_valid = 1'b0;
        data_in     = {$urandom, $urandom};
      end
      @(posedge ap_clk); #1;
    end
    input_valid = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      int best = 0;
      int bidx = 0;
      for (int b = 0; b < NB; b++) begin
        int v = (mcnt[c][b] > SAT) ? SAT : mcnt[c][b];
        exp_q.push_back({1'b0, CNT_W'(v)});
        if (v > best) begin
          best = v;
          bidx = b;
        end
      end
      exp_q.push_back({1'b1, CNT_W'(bidx)});
    end
  endtask

  task automatic wait_done(input int budget);
    int base = done_total;
    int cyc  = 0;
    while (done_total == base && cyc < budget) begin
      junk();
      @(posedge ap_clk); #1;
      cyc++;
    end
    input_valid = 1'b0;
    chk("done_within_budget", 64'(done_total > base), 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    int cyc;
    aresetn      = 1'b0;
    ap_start     = 1'b0;
    input_valid  = 1'b0;
    data_in      = '0;
    accumulation = '0;

    repeat (3) @(posedge ap_clk);
    #1;
    chk("rst_ap_idle", ap_idle, 1);
    chk("rst_ap_done", ap_done, 0);
    chk("rst_freq_write", freq_write, 0);
    chk("rst_mode_write", mode_write, 0);
    chk("rst_freq_din", freq_din, 0);
    chk("rst_mode_din", mode_din, 0);
    chk("rst_state", o_dbg_state, 0);
    aresetn = 1'b1;
    @(posedge ap_clk); #1;

    // Zero-length window: start ignored
    accumulation = 32'd0;
    ap_start     = 1'b1;
    repeat (4) begin
      @(posedge ap_clk); #1;
      chk("zero_acc_stays_idle", ap_idle, 1);
    end
    ap_start = 1'b0;

    // Window and mode
    start_window(10, 1'b0);
    send_samples(10, 0, 1'b0);
    wait_done(3000);
    chk("w1_ch0_bin3", cap_freq[3], 10);
    chk("w1_ch0_bin0", cap_freq[0], 0);
    chk("w1_ch1_bin5", cap_freq[NB+5], 7);
    chk("w1_ch1_bin7", cap_freq[NB+7], 3);
    chk("w1_ch0_mode", cap_mode[0], 3);
    chk("w1_ch1_mode", cap_mode[1], 5);
    chk("w1_ch3_bin0", cap_freq[3*NB], 10);

    // Random windows
    repeat (2) begin
      n = int'($urandom_range(1, 200));
      start_window(n, 1'b0);
      send_samples(n, 2, 1'b0);
      wait_done(3000);
    end

    // Backpressure
    bp_en      = 1'b1;
    stall_left = 20;
    start_window(50, 1'b0);
    send_samples(50, 2, 1'b0);
    wait_done(5000);
    bp_en = 1'b0;
    chk("mode_stall_applied", stall_left, 0);

    // Tie and zero-sample bins
    start_window(10, 1'b0);
    send_samples(10, 3, 1'b0);
    wait_done(3000);
    chk("tie_ch0_bin4", cap_freq[4], 5);
    chk("tie_ch0_bin9", cap_freq[9], 5);
    chk("tie_ch0_mode", cap_mode[0], 4);
    chk("tie_ch3_mode", cap_mode[3], 0);

    // Back-to-back windows with start held: clear-on-read and re-arm
    start_window(4, 1'b1);
    send_samples(4, 4, 1'b1);
    wait_done(3000);
    chk("rearm_idle_cycle", ap_idle, 1);
    input_valid = 1'b0;
    @(posedge ap_clk); #1;
    chk("rearm_accum", ap_idle, 0);
    send_samples(4, 4, 1'b1);
    ap_start = 1'b0;
    wait_done(3000);
    chk("cor_ch0_bin2", cap_freq[2], 4);
    chk("cor_ch1_bin2", cap_freq[NB+2], 4);

    // Reset during readout
    base = freq_total;
    start_window(30, 1'b0);
    send_samples(30, 2, 1'b0);
    cyc = 0;
    while ((freq_total - base) < 37 && cyc < 2000) begin
      @(posedge ap_clk); #1;
      cyc++;
    end
    chk("reached_word_37", freq_total - base, 37);
    aresetn = 1'b0;
    #1;
    chk("midrst_ap_idle", ap_idle, 1);
    chk("midrst_freq_write", freq_write, 0);
    chk("midrst_mode_write", mode_write, 0);
    chk("midrst_ap_done", ap_done, 0);
    exp_q.delete();
    @(posedge ap_clk); #1;
    @(posedge ap_clk); #1;
    aresetn = 1'b1;
`ifdef HIST_DROP_CNT_EN
    repeat (6) begin
      input_valid = 1'b1;
      data_in     = {$urandom, $urandom};
      @(posedge ap_clk); #1;
    end
    input_valid = 1'b0;
    chk("drop_count_idle", drop_count, 6);
`endif
    start_window(20, 1'b0);
`ifdef HIST_DROP_CNT_EN
    chk("drop_count_cleared", drop_count, 0);
`endif
    send_samples(20, 2, 1'b0);
    wait_done(3000);

    // Saturation
    start_window(70000, 1'b0);
    send_samples(70000, 1, 1'b1);
    wait_done(3000);
    for (int c = 0; c < NUM_CH; c++) begin
      chk("sat_bin1", cap_freq[c*NB+1], SAT);
      chk("sat_mode", cap_mode[c], 1);
    end

    repeat (3) @(posedge ap_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
